// File: rtl/register_shift_piso_tx_if.sv
// ---------------------------------------------------------------------------
// register_shift_piso_tx_if
//
// This interface bundles the load handshake and the serial link of the
// parallel-in serial-out transmitter.
//
// Modports:
//   master : the word source and serial receiver side, which is the testbench
//            or the surrounding logic.
//            It drives load_valid, parallel_in and serial_ready.
//   slave  : the transmitter itself.
//            It drives load_ready, serial_out, serial_valid, frame_start,
//            frame_end and busy.
//
// Signals:
//   load_valid   : the source presents parallel_in.
//   load_ready   : the transmitter accepts a word this cycle (combinational).
//   parallel_in  : the WIDTH-bit word to serialize.
//   serial_out   : the current serial bit (registered).
//   serial_valid : serial_out carries a frame bit (registered).
//   serial_ready : the receiver consumes the current bit at this edge.
//   frame_start  : high while the first bit of a frame is shown (registered).
//   frame_end    : high while the last bit of a frame is shown (registered).
//   busy         : the transmitter is in the middle of a frame.
// ---------------------------------------------------------------------------
interface register_shift_piso_tx_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_ready;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid,
    output parallel_in,
    output serial_ready,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  frame_end,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    input  serial_ready,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output frame_end,
    output busy
  );

endinterface

// File: rtl/register_shift_piso_tx.sv
// ---------------------------------------------------------------------------
// register_shift_piso_tx
//
// This is a parallel-in serial-out transmitter for the 4-bit register family.
// It works in three steps:
//   1. It accepts a word over a valid/ready load handshake.
//   2. It shifts the word out one bit per accepted serial beat.
//   3. It marks the first and last bit of each frame with frame_start and
//      frame_end.
//
// A load may be accepted on the last beat of a frame. In that case the next
// frame follows with no idle cycle between the two frames.
//
// Parameters:
//   WIDTH     : word width in bits. It must be at least 2.
//   MSB_FIRST : 1 sends bit WIDTH-1 first. 0 sends bit 0 first.
//
// Ports:
//   clk     : rising-edge clock.
//   clear_n : asynchronous active-low reset.
//   tx      : load handshake and serial link (slave modport of
//             register_shift_piso_tx_if).
// ---------------------------------------------------------------------------
module register_shift_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                    clk,
  input logic                    clear_n,
  register_shift_piso_tx_if.slave tx
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             end_q, end_d;

  logic             loadReady;
  logic             loadAccept;
  logic             beat;
  logic             firstBit;
  logic             nextBit;
  logic [WIDTH-1:0] shifted;

  // The transmitter can take a new word in IDLE. It can also take one on the
  // last beat of a frame, which keeps back-to-back frames gapless.
  assign loadReady  = (state_q == IDLE) ||
                      ((state_q == SHIFT) && end_q && tx.serial_ready);
  assign loadAccept = tx.load_valid && loadReady;
  assign beat       = (state_q == SHIFT) && valid_q && tx.serial_ready;

  // The output end of the shift register depends on the shift direction.
  // nextBit is the bit that moves into the output position on a beat.
  assign firstBit = MSB_FIRST ? tx.parallel_in[WIDTH-1] : tx.parallel_in[0];
  assign nextBit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shifted  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  // This is the state register. Reset aborts any frame in progress.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  // This block computes the next state. Every register holds unless a load
  // or a beat happens, so a stalled beat repeats identical outputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    start_d = start_q;
    end_d   = end_q;

    unique case (state_q)
      IDLE: begin
        if (loadAccept) begin
          state_d = SHIFT;
          shreg_d = tx.parallel_in;
          cnt_d   = CNT_LAST;
          out_d   = firstBit;
          valid_d = 1'b1;
          start_d = 1'b1;
          end_d   = 1'b0;
        end
      end

      SHIFT: begin
        if (beat) begin
          if (cnt_q == '0) begin
            if (loadAccept) begin
              shreg_d = tx.parallel_in;
              cnt_d   = CNT_LAST;
              out_d   = firstBit;
              valid_d = 1'b1;
              start_d = 1'b1;
              end_d   = 1'b0;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
              out_d   = 1'b0;
              valid_d = 1'b0;
              start_d = 1'b0;
              end_d   = 1'b0;
            end
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q - 1'b1;
            out_d   = nextBit;
            start_d = 1'b0;
            end_d   = (cnt_q == CNT_W'(1));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx.load_ready   = loadReady;
  assign tx.serial_out   = out_q;
  assign tx.serial_valid = valid_q;
  assign tx.frame_start  = start_q;
  assign tx.frame_end    = end_q;
  assign tx.busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_register_shift_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_register_shift_piso_tx
//
// Two transmitters receive the same stimulus. One sends MSB first and the
// other sends LSB first.
//
// A frame-level model tracks each transmitter's word, bit position and
// active flag. The bench compares each transmitter's outputs with this model
// every cycle.
//
// The bench also collects the serial bits that are consumed. It compares
// them with the bit streams expected from the directed scenarios.
// ---------------------------------------------------------------------------
module tb_register_shift_piso_tx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic clear_n;

  int checkCount = 0;
  int failCount  = 0;

  // Model state. Index 0 is the MSB-first transmitter and index 1 is the
  // LSB-first transmitter.
  bit           mActive[2];
  int           mPos[2];
  logic [W-1:0] mWord[2];
  logic [31:0]  cap[2];
  string        tags[2] = '{"msb", "lsb"};

  always #5 clk = ~clk;

  register_shift_piso_tx_if #(.WIDTH(W)) ifMsb ();
  register_shift_piso_tx_if #(.WIDTH(W)) ifLsb ();

  register_shift_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk     (clk),
    .clear_n (clear_n),
    .tx      (ifMsb)
  );

  register_shift_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk     (clk),
    .clear_n (clear_n),
    .tx      (ifLsb)
  );

  // This task counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s observed='h%0h expected='h%0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input logic lv, input logic [W-1:0] word,
                             input logic sr);
    ifMsb.load_valid   = lv;
    ifMsb.parallel_in  = word;
    ifMsb.serial_ready = sr;
    ifLsb.load_valid   = lv;
    ifLsb.parallel_in  = word;
    ifLsb.serial_ready = sr;
  endtask

  // The outputs are packed as {valid, out, start, end, busy, load_ready}.
  function automatic logic [5:0] observed(input int i);
    if (i == 0)
      return {ifMsb.serial_valid, ifMsb.serial_out, ifMsb.frame_start,
              ifMsb.frame_end, ifMsb.busy, ifMsb.load_ready};
    return {ifLsb.serial_valid, ifLsb.serial_out, ifLsb.frame_start,
            ifLsb.frame_end, ifLsb.busy, ifLsb.load_ready};
  endfunction

  function automatic logic [5:0] expected(input int i, input logic sr);
    int   idx;
    logic b;
    idx = (i == 0) ? (W - 1 - mPos[i]) : mPos[i];
    b   = mActive[i] ? mWord[i][idx] : 1'b0;
    return {mActive[i], b, mActive[i] && (mPos[i] == 0),
            mActive[i] && (mPos[i] == W - 1), mActive[i],
            !mActive[i] || ((mPos[i] == W - 1) && sr)};
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < 2; i++) begin
      mActive[i] = 1'b0;
      mPos[i]    = 0;
      mWord[i]   = '0;
    end
  endfunction

  // At each clock edge, a frame either starts fresh on a load, moves to the
  // next bit on a consumed bit, or ends after its last bit.
  function automatic void modelStep(input int i, input logic lv,
                                    input logic [W-1:0] word, input logic sr);
    bit ready;
    bit consumed;
    ready    = !mActive[i] || ((mPos[i] == W - 1) && sr);
    consumed = mActive[i] && sr;
    if (lv && ready) begin
      mWord[i]   = word;
      mPos[i]    = 0;
      mActive[i] = 1'b1;
    end else if (consumed) begin
      if (mPos[i] == W - 1) mActive[i] = 1'b0;
      else                  mPos[i]++;
    end
  endfunction

  // This task runs one clock cycle. It drives inputs after the falling edge,
  // checks outputs 1 time unit later, and then advances the model on the
  // rising edge.
  task automatic applyStimulus(input logic lv, input logic [W-1:0] word,
                               input logic sr);
    logic [5:0] o;
    driveInputs(lv, word, sr);
    #1;
    for (int i = 0; i < 2; i++) begin
      o = observed(i);
      checkOutput({tags[i], ".outs"}, {26'd0, o}, {26'd0, expected(i, sr)});
      if (o[5] && sr) cap[i] = {cap[i][30:0], o[4]};
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i, lv, word, sr);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < 2; i++)
      checkOutput({tags[i], tag}, {26'd0, observed(i)}, 32'h01);
  endtask

  task automatic clearCapture();
    cap[0] = '0;
    cap[1] = '0;
  endtask

  initial begin
    clear_n = 1'b0;
    driveInputs(1'b0, '0, 1'b0);
    resetModel();
    clearCapture();

    // Reset is held for two cycles and then released with the inputs idle.
    #1;
    checkResetOutputs(".reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);

    // Single frame.
    clearCapture();
    applyStimulus(1'b1, 4'b1101, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("msb.single", cap[0], 32'hD);
    checkOutput("lsb.single", cap[1], 32'hB);

    // Back-to-back: the second word waits on load_valid until the last beat.
    clearCapture();
    applyStimulus(1'b1, 4'b1011, 1'b1);
    repeat (4) applyStimulus(1'b1, 4'b0110, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("msb.b2b", cap[0], 32'hB6);
    checkOutput("lsb.b2b", cap[1], 32'hD6);

    // Backpressure: bit 2 is stalled for three cycles.
    clearCapture();
    applyStimulus(1'b1, 4'b1010, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("msb.stall", cap[0], 32'hA);
    checkOutput("lsb.stall", cap[1], 32'h5);

    // Ignored load: a load_valid pulse in the middle of a frame has no effect.
    clearCapture();
    applyStimulus(1'b1, 4'b0101, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("msb.ignored", cap[0], 32'h5);
    checkOutput("lsb.ignored", cap[1], 32'hA);

    // Reset abort: reset is asserted while bit 3 of 0110 is shown.
    applyStimulus(1'b1, 4'b0110, 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    #2;
    clear_n = 1'b0;
    #1;
    checkResetOutputs(".abort");
    repeat (2) @(posedge clk);
    resetModel();
    @(negedge clk);
    clear_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);

    // Random traffic is checked against the model every cycle.
    repeat (400)
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom),
                    ($urandom_range(0, 3) != 0));
    repeat (2 * W) applyStimulus(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
